popcount_stream: RTL and testbench



---
 rtl/popcount_pkg.sv | 34 +++
 rtl/adder_nbit_cout.sv | 18 +
 rtl/popcount_tree_level.sv | 61 ++++++
 rtl/popcount_stream.sv | 144 ++++++++++++++
 tb/tb_popcount_stream.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/popcount_pkg.sv
// popcount_pkg
//   Shared definitions for the streaming popcount engine:
//   - clog2 / cnt_width helpers used to size the adder tree and the count
//   - mode encodings carried alongside each word
//   - tag_t: the {valid, mode, last} bundle that travels with the data
package popcount_pkg;

    localparam logic MODE_WORD = 1'b0;  // emit each word's own count
    localparam logic MODE_ACC  = 1'b1;  // sum counts across a packet

    typedef struct packed {
        logic valid;
        logic mode;
        logic last;
    } tag_t;

    // Ceiling log2 for elaboration-time sizing (value >= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width of a single-word count: must hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return clog2(width) + 1;
    endfunction

endpackage

// File: rtl/adder_nbit_cout.sv
// adder_nbit_cout
//   N-bit unsigned adder with carry out.
//   Ports:
//     i_a, i_b : N-bit operands
//     o_sum    : N-bit sum
//     o_cout   : carry out of the top bit
module adder_nbit_cout #(
    parameter int N = 1
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/popcount_tree_level.sv
// popcount_tree_level
//   One registered level of the popcount adder tree. Adds adjacent IN_W-bit
//   partials pairwise into (IN_W+1)-bit partials and registers the result
//   together with the word's tag.
//   Ports:
//     clk, rst : clock, synchronous active-high reset (clears data and tag)
//     i_en     : global advance enable; when low the level holds, bubbles too
//     i_data   : IN_N partials of IN_W bits, partial 0 in the LSBs
//     i_tag    : {valid, mode, last} of the word in i_data
//     o_data   : IN_N/2 partials of IN_W+1 bits (registered)
//     o_tag    : registered tag
module popcount_tree_level
    import popcount_pkg::*;
#(
    parameter int IN_N = 8,
    parameter int IN_W = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_en,
    input  logic [IN_N*IN_W-1:0]              i_data,
    input  tag_t                              i_tag,
    output logic [(IN_N/2)*(IN_W+1)-1:0]      o_data,
    output tag_t                              o_tag
);

    localparam int OUT_N = IN_N / 2;
    localparam int OUT_W = IN_W + 1;

    logic [OUT_N*OUT_W-1:0] w_sum;
    logic [OUT_N*OUT_W-1:0] r_data;
    tag_t                   r_tag;

    for (genvar j = 0; j < OUT_N; j++) begin : g_pair
        logic [IN_W-1:0] w_low;
        logic            w_cout;

        adder_nbit_cout #(.N(IN_W)) u_add (
            .i_a    (i_data[(2*j)*IN_W +: IN_W]),
            .i_b    (i_data[(2*j+1)*IN_W +: IN_W]),
            .o_sum  (w_low),
            .o_cout (w_cout)
        );

        assign w_sum[j*OUT_W +: OUT_W] = {w_cout, w_low};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_tag  <= '0;
        end else if (i_en) begin
            r_data <= w_sum;
            r_tag  <= i_tag;
        end
    end

    assign o_data = r_data;
    assign o_tag  = r_tag;

endmodule

// File: rtl/popcount_stream.sv
// popcount_stream
//   Streaming, pipelined popcount engine. One WIDTH-bit word per cycle is
//   reduced through clog2(WIDTH) registered adder levels followed by one
//   output register (latency clog2(WIDTH)+1 cycles).
//   Per-word mode emits each word's count; accumulate mode sums counts over a
//   packet (saturating at 2^ACC_W-1) and emits one total on the last word.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     in_valid/in_ready   : input handshake, word accepted on valid & ready
//     in_data             : word to count
//     in_mode             : 0 per-word, 1 accumulate (travels with the word)
//     in_last             : end of packet, only meaningful in accumulate mode
//     out_valid/out_ready : result handshake, consumed on valid & ready
//     out_count           : result, zero-extended to ACC_W
//     out_sat             : accumulated total saturated
//
//   Handshake: a transfer happens on a rising edge where valid & ready are
//   both high. out_valid/out_count/out_sat hold while out_valid & !out_ready.
//   The whole pipeline shares one advance enable en = !out_valid | out_ready,
//   and in_ready is exactly en, so when the sink stalls every stage (bubbles
//   included) holds and no word is accepted.
module popcount_stream
    import popcount_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_count,
    output logic             out_sat
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int L     = clog2(WIDTH);

    // Bit offset of tree level k's input inside the flat w_bus. Level k
    // input holds (WIDTH >> k) partials of (k+1) bits; level L "input" is
    // the final CNT_W-bit count.
    function automatic int lvl_off(input int k);
        int o;
        o = 0;
        for (int j = 0; j < k; j++) begin
            o += (WIDTH >> j) * (j + 1);
        end
        return o;
    endfunction

    localparam int BUS_W = lvl_off(L + 1);

    logic             w_en;
    logic [BUS_W-1:0] w_bus;
    tag_t             w_tag [0:L];
    tag_t             w_tail_tag;
    logic [CNT_W-1:0] w_cnt;
    logic [ACC_W-1:0] w_cnt_ext;
    logic [ACC_W:0]   w_acc_sum;
    logic             w_acc_ovf;
    logic [ACC_W-1:0] w_acc_next;

    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_count;
    logic             r_out_sat;
    logic [ACC_W-1:0] r_acc;
    logic             r_sat;

    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    assign w_bus[lvl_off(0) +: WIDTH] = in_data;
    assign w_tag[0] = '{valid: in_valid, mode: in_mode, last: in_last};

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int IN_N    = WIDTH >> k;
        localparam int IN_W    = k + 1;
        localparam int OUT_BIT = (IN_N / 2) * (IN_W + 1);

        popcount_tree_level #(
            .IN_N (IN_N),
            .IN_W (IN_W)
        ) u_level (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_en),
            .i_data (w_bus[lvl_off(k) +: IN_N*IN_W]),
            .i_tag  (w_tag[k]),
            .o_data (w_bus[lvl_off(k+1) +: OUT_BIT]),
            .o_tag  (w_tag[k+1])
        );
    end

    assign w_tail_tag = w_tag[L];
    assign w_cnt      = w_bus[lvl_off(L) +: CNT_W];
    assign w_cnt_ext  = ACC_W'(w_cnt);

    // One extra bit catches the overflow; the add then clamps to all-ones.
    assign w_acc_sum  = {1'b0, r_acc} + {1'b0, w_cnt_ext};
    assign w_acc_ovf  = w_acc_sum[ACC_W];
    assign w_acc_next = w_acc_ovf ? {ACC_W{1'b1}} : w_acc_sum[ACC_W-1:0];

    // Output register and accumulator. Both only move when the tree tail
    // advances (w_en) carrying a valid word; bubbles just clear out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
            r_acc       <= '0;
            r_sat       <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= 1'b0;
            if (w_tail_tag.valid) begin
                if (w_tail_tag.mode == MODE_WORD) begin
                    r_out_valid <= 1'b1;
                    r_out_count <= w_cnt_ext;
                    r_out_sat   <= 1'b0;
                end else if (w_tail_tag.mode == MODE_ACC) begin
                    if (w_tail_tag.last) begin
                        r_out_valid <= 1'b1;
                        r_out_count <= w_acc_next;
                        r_out_sat   <= r_sat || w_acc_ovf;
                        r_acc       <= '0;
                        r_sat       <= 1'b0;
                    end else begin
                        r_acc <= w_acc_next;
                        r_sat <= r_sat || w_acc_ovf;
                    end
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_count = r_out_count;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_popcount_stream.sv
module tb_popcount_stream;

  // ---------------- clock / reset / DUTs ----------------
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_mode;
  logic        in_last;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_count;
  logic        out_sat;

  logic        in_ready2;
  logic        out_valid2;
  logic [3:0]  out_count2;
  logic        out_sat2;

  int checks;
  int failures;
  int cyc;

  logic [16:0] obs_q[$];
  int          obs_t[$];
  logic [4:0]  obs2_q[$];
  logic [16:0] exp_q[$];
  logic [4:0]  exp2_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  popcount_stream #(.WIDTH(8), .ACC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  // Narrow accumulator instance for saturation (CNT_W = ACC_W = 4).
  popcount_stream #(.WIDTH(8), .ACC_W(4)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_count (out_count2),
    .out_sat   (out_sat2)
  );

  // Monitor: record each result consumed on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      obs_q.push_back({out_sat, out_count});
      obs_t.push_back(cyc);
    end
    if (!rst && out_valid2 && out_ready) begin
      obs2_q.push_back({out_sat2, out_count2});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Entered just after a rising edge; applies inputs for one cycle, samples
  // acceptance on the falling edge and returns just after the next rising edge.
  task automatic drive_cycle(input logic r, input logic v, input logic [7:0] d,
                             input logic m, input logic l, input logic rdy,
                             output logic acc);
    rst       = r;
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    in_last   = l;
    out_ready = rdy;
    @(negedge clk);
    acc = v & in_ready & !r;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic m, input logic l);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      drive_cycle(1'b0, 1'b1, d, m, l, 1'b1, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout word=%h not accepted within 20 cycles", d);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) begin
      drive_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic acc;
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (out_count !== 16'd0) begin
      failures++; $display("FAIL reset_out_count got=%0d exp=0", out_count);
    end
    checks++;
    if (out_sat !== 1'b0) begin
      failures++; $display("FAIL reset_out_sat got=%b exp=0", out_sat);
    end
    rst = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    drive_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
  endtask

  task automatic test_per_word();
    logic [7:0]  words [4];
    logic        acc;
    logic [16:0] got;
    words = '{8'h00, 8'hFF, 8'hA5, 8'h01};
    obs_q.delete(); obs_t.delete(); exp_q.delete();
    exp_q.push_back({1'b0, 16'd0});
    exp_q.push_back({1'b0, 16'd8});
    exp_q.push_back({1'b0, 16'd4});
    exp_q.push_back({1'b0, 16'd1});
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b1, words[i], 1'b0, 1'b0, 1'b1, acc);
      if (i == 2) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++; $display("FAIL word_latency_early out_valid got=%b exp=0 after 3 edges", out_valid);
        end
      end
      if (i == 3) begin
        checks++;
        if (out_valid !== 1'b1 || out_count !== 16'd0) begin
          failures++;
          $display("FAIL word_latency_first got valid=%b count=%0d exp valid=1 count=0", out_valid, out_count);
        end
      end
    end
    idle(6);
    checks++;
    if (obs_q.size() != 4) begin
      failures++; $display("FAIL word_result_count got=%0d exp=4", obs_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 17'bx;
      checks++;
      if (got !== exp_q[i]) begin
        failures++; $display("FAIL word_result[%0d] got=%h exp=%h", i, got, exp_q[i]);
      end
    end
    for (int i = 1; i < obs_t.size(); i++) begin
      checks++;
      if (obs_t[i] - obs_t[i-1] != 1) begin
        failures++; $display("FAIL word_throughput[%0d] gap got=%0d exp=1", i, obs_t[i] - obs_t[i-1]);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0]  words [6];
    logic        pat [6];
    logic        acc;
    logic        hold_pending;
    logic [15:0] held;
    logic [16:0] got;
    int          idx;
    int          c;
    words = '{8'h03, 8'h7F, 8'h80, 8'hF0, 8'h55, 8'hFE};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    obs_q.delete(); obs_t.delete(); exp_q.delete();
    exp_q.push_back({1'b0, 16'd2});
    exp_q.push_back({1'b0, 16'd7});
    exp_q.push_back({1'b0, 16'd1});
    exp_q.push_back({1'b0, 16'd4});
    exp_q.push_back({1'b0, 16'd4});
    exp_q.push_back({1'b0, 16'd7});
    idx = 0;
    c = 0;
    hold_pending = 1'b0;
    held = '0;
    while ((idx < 6 || obs_q.size() < 6) && c < 80) begin
      rst       = 1'b0;
      out_ready = pat[c % 6];
      in_valid  = (idx < 6);
      in_data   = (idx < 6) ? words[idx] : 8'h00;
      in_mode   = 1'b0;
      in_last   = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        failures++;
        $display("FAIL stall_in_ready cycle=%0d got=%b exp=%b", c, in_ready, (!out_valid || out_ready));
      end
      if (hold_pending) begin
        checks++;
        if (out_valid !== 1'b1 || out_count !== held) begin
          failures++;
          $display("FAIL stall_hold cycle=%0d got valid=%b count=%0d exp valid=1 count=%0d", c, out_valid, out_count, held);
        end
      end
      hold_pending = out_valid && !out_ready;
      held = out_count;
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      c++;
    end
    checks++;
    if (c >= 80) begin
      failures++; $display("FAIL stall_timeout accepted=%0d results=%0d exp 6/6", idx, obs_q.size());
    end
    idle(6);
    checks++;
    if (obs_q.size() != 6) begin
      failures++; $display("FAIL stall_result_count got=%0d exp=6", obs_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 17'bx;
      checks++;
      if (got !== exp_q[i]) begin
        failures++; $display("FAIL stall_result[%0d] got=%h exp=%h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_accumulate();
    logic [16:0] got;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back({1'b0, 16'd14});
    exp_q.push_back({1'b0, 16'd1});
    send(8'hFF, 1'b1, 1'b0);
    send(8'h0F, 1'b1, 1'b0);
    send(8'h03, 1'b1, 1'b1);
    send(8'h01, 1'b1, 1'b1);
    idle(8);
    checks++;
    if (obs_q.size() != 2) begin
      failures++; $display("FAIL acc_result_count got=%0d exp=2", obs_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 17'bx;
      checks++;
      if (got !== exp_q[i]) begin
        failures++; $display("FAIL acc_result[%0d] got=%h exp=%h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [4:0]  got2;
    logic [16:0] got;
    obs_q.delete(); obs2_q.delete(); exp_q.delete(); exp2_q.delete();
    exp2_q.push_back({1'b1, 4'd15});
    exp2_q.push_back({1'b0, 4'd2});
    exp_q.push_back({1'b0, 16'd24});
    exp_q.push_back({1'b0, 16'd2});
    send(8'hFF, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b1);
    send(8'h03, 1'b1, 1'b1);
    idle(8);
    checks++;
    if (obs2_q.size() != 2) begin
      failures++; $display("FAIL sat_result_count got=%0d exp=2", obs2_q.size());
    end
    for (int i = 0; i < exp2_q.size(); i++) begin
      got2 = (i < obs2_q.size()) ? obs2_q[i] : 5'bx;
      checks++;
      if (got2 !== exp2_q[i]) begin
        failures++; $display("FAIL sat_result[%0d] {sat,count} got=%b exp=%b", i, got2, exp2_q[i]);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 17'bx;
      checks++;
      if (got !== exp_q[i]) begin
        failures++; $display("FAIL wide_acc_result[%0d] got=%h exp=%h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_interleave();
    logic [16:0] got;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back({1'b0, 16'd3});
    exp_q.push_back({1'b0, 16'd9});
    send(8'hFF, 1'b1, 1'b0);
    send(8'h07, 1'b0, 1'b1);  // last with per-word mode must not close the packet
    send(8'h01, 1'b1, 1'b1);
    idle(8);
    checks++;
    if (obs_q.size() != 2) begin
      failures++; $display("FAIL mix_result_count got=%0d exp=2", obs_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 17'bx;
      checks++;
      if (got !== exp_q[i]) begin
        failures++; $display("FAIL mix_result[%0d] got=%h exp=%h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midpacket();
    logic        acc;
    logic [16:0] got;
    send(8'h1F, 1'b1, 1'b0);   // accumulator now 5
    idle(6);
    send(8'hFF, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
    checks++;
    if (out_valid !== 1'b0 || out_count !== 16'd0) begin
      failures++;
      $display("FAIL midreset_out got valid=%b count=%0d exp valid=0 count=0", out_valid, out_count);
    end
    obs_q.delete(); exp_q.delete();
    exp_q.push_back({1'b0, 16'd2});
    send(8'h03, 1'b1, 1'b1);
    idle(8);
    checks++;
    if (obs_q.size() != 1) begin
      failures++; $display("FAIL midreset_result_count got=%0d exp=1", obs_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 17'bx;
      checks++;
      if (got !== exp_q[i]) begin
        failures++; $display("FAIL midreset_result[%0d] got=%h exp=%h", i, got, exp_q[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_mode   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_per_word();
    test_stall();
    test_accumulate();
    test_saturate();
    test_interleave();
    test_reset_midpacket();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
